// File: rtl/dpsched.sv
// ---------------------------------------------------------------------------
// dpsched - DisplayPort main-link frame scheduler (4 lanes, 32-bit link word)
//
// Generates line/frame timing for the link word path, inserts the BS, VB-ID
// and BE control symbols plus blanking fill, and pulls pixel words from the
// pixel-to-link-word converter during the active region of each line.
//
// Ports
//   clk         in   1   clock
//   reset       in   1   synchronous, active-high reset
//   enable      in   1   link trained (level)
//   fifo_empty  in   1   converter pixel FIFO empty
//   conv_dat    in   32  converter word, valid combinationally with consume
//   consume     out  1   take conv_dat this cycle
//   restart     out  1   hold converter in frame resync
//   link_dat    out  32  link word, lane n = byte n (registered)
//   link_k      out  4   per-lane K-symbol flag (registered)
//   vblank      out  1   current line is vertical blanking (registered)
//   underflow   out  1   sticky: FIFO empty seen while consuming
// ---------------------------------------------------------------------------
module dpsched #(
    parameter int HBL  = 16,   // blanking words per line (>= 4)
    parameter int HACT = 480,  // active words per line
    parameter int VBL  = 45,   // vertical-blanking lines per frame (>= 1)
    parameter int VACT = 480   // active lines per frame
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [31:0] conv_dat,
    output logic        consume,
    output logic        restart,
    output logic [31:0] link_dat,
    output logic [3:0]  link_k,
    output logic        vblank,
    output logic        underflow
);

    localparam int HTOT = HBL + HACT;
    localparam int VTOT = VBL + VACT;
    localparam int HW   = $clog2(HTOT);
    localparam int VW   = $clog2(VTOT);

    localparam logic [HW-1:0] H_LAST = HW'(HTOT - 1);
    localparam logic [HW-1:0] H_BE   = HW'(HBL - 1);
    localparam logic [HW-1:0] H_ACT0 = HW'(HBL);
    localparam logic [VW-1:0] V_LAST = VW'(VTOT - 1);
    localparam logic [VW-1:0] V_ACT0 = VW'(VBL);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BLANK  = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;

    localparam logic [31:0] WORD_BS = 32'hBCBC_BCBC;
    localparam logic [31:0] WORD_BE = 32'hFBFB_FBFB;

    logic [1:0]    state_q, state_d;
    logic [HW-1:0] hpos_q, hpos_d;
    logic [VW-1:0] vpos_q, vpos_d;
    logic [31:0]   link_dat_q, link_dat_d;
    logic [3:0]    link_k_q, link_k_d;
    logic          vblank_q;
    logic          underflow_q;
    logic          pend_q, pend_d;

    logic line_is_vbl;
    logic restart_pulse;
    logic uf_set;

    assign line_is_vbl   = (vpos_q < V_ACT0);
    assign restart_pulse = (state_q == S_BLANK) && (hpos_q == '0) && (vpos_q == '0) && pend_q;
    assign uf_set        = (state_q == S_ACTIVE) && fifo_empty;

    // The state always classifies the current (vpos, hpos); both strobes
    // are decoded from it so restart can never overlap consume.
    assign consume   = (state_q == S_ACTIVE);
    assign restart   = (state_q == S_IDLE) || restart_pulse;
    assign link_dat  = link_dat_q;
    assign link_k    = link_k_q;
    assign vblank    = vblank_q;
    assign underflow = underflow_q;

    // Position counters and state.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        state_d = state_q;
        hpos_d  = hpos_q;
        vpos_d  = vpos_q;
        if (state_q == S_IDLE) begin
            hpos_d  = '0;
            vpos_d  = '0;
            state_d = enable ? S_BLANK : S_IDLE;
        end else if (!enable) begin
            // Partial line is abandoned; re-enable starts a fresh frame.
            hpos_d  = '0;
            vpos_d  = '0;
            state_d = S_IDLE;
        end else begin
            if (hpos_q == H_LAST) begin
                hpos_d = '0;
                vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + 1'b1;
            end else begin
                hpos_d = hpos_q + 1'b1;
            end
            state_d = ((vpos_d >= V_ACT0) && (hpos_d >= H_ACT0)) ? S_ACTIVE : S_BLANK;
        end
    end

    // Link word for the current position; registered below.
    always_comb begin
        link_dat_d = '0;
        link_k_d   = 4'b0000;
        case (state_q)
            S_ACTIVE: link_dat_d = conv_dat;
            S_BLANK: begin
                if (hpos_q == '0) begin
                    link_dat_d = WORD_BS;
                    link_k_d   = 4'b1111;
                end else if (hpos_q == HW'(1)) begin
                    link_dat_d = {4{7'b0, line_is_vbl}};
                end else if ((hpos_q == H_BE) && !line_is_vbl) begin
                    link_dat_d = WORD_BE;
                    link_k_d   = 4'b1111;
                end
            end
            default: ;
        endcase
    end

    // An underflow arms one converter resync at the next frame start.
    always_comb begin
        pend_d = pend_q;
        if (uf_set)
            pend_d = 1'b1;
        else if (restart_pulse)
            pend_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q     <= S_IDLE;
            hpos_q      <= '0;
            vpos_q      <= '0;
            link_dat_q  <= '0;
            link_k_q    <= 4'b0000;
            vblank_q    <= 1'b1;
            underflow_q <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hpos_q      <= hpos_d;
            vpos_q      <= vpos_d;
            link_dat_q  <= link_dat_d;
            link_k_q    <= link_k_d;
            vblank_q    <= line_is_vbl;
            underflow_q <= underflow_q | uf_set;
            pend_q      <= pend_d;
        end
    end

endmodule

// File: tb/tb_dpsched.sv
// ---------------------------------------------------------------------------
// tb_dpsched - self-checking bench for dpsched
//
// Uses a reduced timing (HBL=5, HACT=8, VBL=2, VACT=3: 13-word lines, 5-line
// frames) so several whole frames fit in a short run. The stimulus process
// drives inputs on the falling edge and pushes the outputs the DUT must show
// at that moment into a scoreboard queue; the monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_dpsched;

    localparam int HBL  = 5;
    localparam int HACT = 8;
    localparam int VBL  = 2;
    localparam int VACT = 3;
    localparam int HTOT = HBL + HACT;
    localparam int VTOT = VBL + VACT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_empty = 1'b0;
    logic [31:0] conv_dat = '0;
    logic        consume, restart, vblank, underflow;
    logic [31:0] link_dat;
    logic [3:0]  link_k;

    dpsched #(.HBL(HBL), .HACT(HACT), .VBL(VBL), .VACT(VACT)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .conv_dat   (conv_dat),
        .consume    (consume),
        .restart    (restart),
        .link_dat   (link_dat),
        .link_k     (link_k),
        .vblank     (vblank),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          consume;
        bit          restart;
        logic [31:0] dat;
        logic [3:0]  k;
        bit          vb;
        bit          uf;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc_n = 0;
    bit   count_en = 1'b0;
    int   cons_cnt = 0;
    int   rst_cnt = 0;

    // Reference: what the link must be doing, tracked from the inputs applied.
    bit          m_run = 1'b0;
    int          m_v = 0, m_h = 0, m_frame = 0;
    bit          m_pend = 1'b0, m_uf = 1'b0;
    logic [31:0] m_dat = '0;
    logic [3:0]  m_k = '0;
    bit          m_vb = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_act(input int v, input int h);
        return (v >= VBL) && (h >= HBL);
    endfunction

    task automatic step(input bit en, input bit rst, input bit fe, input logic [31:0] dat, input bit ce);
        exp_t e;
        @(negedge clk);
        enable = en; reset = rst; fifo_empty = fe; conv_dat = dat; count_en = ce;
        cyc_n++;
        e.consume = m_run && is_act(m_v, m_h);
        e.restart = !m_run || (m_v == 0 && m_h == 0 && m_pend);
        e.dat = m_dat; e.k = m_k; e.vb = m_vb; e.uf = m_uf; e.cyc = cyc_n;
        sb.push_back(e);
        if (rst) begin
            m_run = 0; m_v = 0; m_h = 0; m_pend = 0; m_uf = 0;
            m_dat = '0; m_k = '0; m_vb = 1;
        end else begin
            m_dat = '0; m_k = 4'b0000;
            if (m_run) begin
                if (is_act(m_v, m_h)) m_dat = dat;
                else if (m_h == 0) begin m_dat = 32'hBCBCBCBC; m_k = 4'b1111; end
                else if (m_h == 1) m_dat = (m_v < VBL) ? 32'h01010101 : 32'h00000000;
                else if (m_h == HBL - 1 && m_v >= VBL) begin m_dat = 32'hFBFBFBFB; m_k = 4'b1111; end
            end
            m_vb = m_run ? (m_v < VBL) : 1'b1;
            if (m_run && is_act(m_v, m_h) && fe) begin
                m_uf = 1; m_pend = 1;
            end else if (m_run && m_v == 0 && m_h == 0 && m_pend) begin
                m_pend = 0;
            end
            if (!m_run) begin
                if (en) m_run = 1;
            end else if (!en) begin
                m_run = 0; m_v = 0; m_h = 0;
            end else if (m_h == HTOT - 1) begin
                m_h = 0;
                if (m_v == VTOT - 1) begin m_v = 0; m_frame++; end
                else m_v++;
            end else begin
                m_h++;
            end
        end
    endtask

    // Converter word: a marker for the very first active word, else a tag of position.
    task automatic cyc(input bit en, input bit rst, input bit fe, input bit ce = 1'b0);
        logic [31:0] d;
        d = (m_v == VBL && m_h == HBL) ? 32'h12345678
                                        : {8'hC0, 8'(m_frame), 8'(m_v), 8'(m_h)};
        step(en, rst, fe, d, ce);
    endtask

    // Monitor: samples mid-low-phase, after the falling-edge stimulus settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("consume@%0d", e.cyc), 32'(consume), 32'(e.consume));
                check($sformatf("restart@%0d", e.cyc), 32'(restart), 32'(e.restart));
                check($sformatf("link_dat@%0d", e.cyc), link_dat, e.dat);
                check($sformatf("link_k@%0d", e.cyc), 32'(link_k), 32'(e.k));
                check($sformatf("vblank@%0d", e.cyc), 32'(vblank), 32'(e.vb));
                check($sformatf("underflow@%0d", e.cyc), 32'(underflow), 32'(e.uf));
                if (count_en) begin
                    cons_cnt += int'(consume);
                    rst_cnt  += int'(restart);
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        repeat (10) cyc(1'b0, 1'b1, 1'b0);
        repeat (10) cyc(1'b0, 1'b0, 1'b0);

        // Enable, then three whole frames; one FIFO-empty word in frame 0.
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3 * HTOT * VTOT; i++)
            cyc(1'b1, 1'b0, (m_frame == 0 && m_v == 3 && m_h == 7), 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        check("consume_3_frames", cons_cnt, 3 * HACT * VACT);
        check("restart_pulses_3_frames", rst_cnt, 1);
        check("underflow_sticky", 32'(underflow), 32'd1);

        // Drop enable mid active line, idle a while, re-enable.
        for (int i = 0; i < 2 * HTOT * VTOT && !(m_v == 3 && m_h == 6); i++)
            cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 1'b0, 1'b0);
        repeat (3 * HTOT) cyc(1'b1, 1'b0, 1'b0);

        // Reset while active with enable held.
        for (int i = 0; i < 2 * HTOT * VTOT && !(m_v == 2 && m_h == 9); i++)
            cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        repeat (2 * HTOT) cyc(1'b1, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
